ramb16_bit_fifo_ctrl: RTL and testbench

//  Sequencer that turns one 16K x 1 dual-port block RAM (RAMB16_S1_S1, instantiated beside it) into a

---
 rtl/rigel_bram_pkg.sv | 33 +++
 rtl/bit_skid2.sv | 56 +++++
 rtl/ramb16_bit_fifo_ctrl.sv | 103 ++++++++++
 tb/tb_ramb16_bit_fifo_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rigel_bram_pkg.sv
// RAMB16 geometry helpers and the RAM control-strobe bundle shared by block-RAM sequencers.
// Pure declarations: no latency, no backpressure.
package rigel_bram_pkg;

  // Address width of one RAMB16 for each supported aspect ratio (data width incl. parity).
  function automatic int ramb16_addr_w(input int data_w);
    int aw;
    case (data_w)
      1:       aw = 14;
      2:       aw = 13;
      4:       aw = 12;
      9:       aw = 11;
      18:      aw = 10;
      36:      aw = 9;
      default: aw = 14;
    endcase
    return aw;
  endfunction

  function automatic int ramb16_depth(input int data_w);
    return 1 << ramb16_addr_w(data_w);
  endfunction

  typedef struct packed {
    logic ena;
    logic wea;
    logic enb;
    logic web;
    logic ssra;
    logic ssrb;
  } ram_ctl_t;

endpackage

// File: rtl/bit_skid2.sv
// 2-entry 1-bit ready/valid skid buffer; data registered, visible the cycle after capture.
// Upstream must never write while full and not popping; clr empties it synchronously.
module bit_skid2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_vld,
  input  logic       in_dat,
  input  logic       out_rdy,
  output logic       out_vld,
  output logic       out_dat,
  output logic [1:0] occ
);

  logic d0, d1;
  logic pop;

  assign out_vld = (occ != 2'd0);
  assign out_dat = d0;
  assign pop     = out_vld & out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= 2'd0;
      d0  <= 1'b0;
      d1  <= 1'b0;
    end else if (clr) begin
      occ <= 2'd0;
      d0  <= 1'b0;
      d1  <= 1'b0;
    end else begin
      case ({in_vld, pop})
        2'b10: begin
          if (occ == 2'd0) d0 <= in_dat;
          else             d1 <= in_dat;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          d0  <= d1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          // head leaves; new bit lands behind whatever remains
          if (occ == 2'd1) begin
            d0 <= in_dat;
          end else begin
            d0 <= d1;
            d1 <= in_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ramb16_bit_fifo_ctrl.sv
// Bit FIFO sequencer over an external 16Kx1 dual-port RAM; push-to-out_valid takes 3 edges.
// in_ready drops only at count==DEPTH; fetches stall so the 2-entry skid never overflows.
module ramb16_bit_fifo_ctrl
  import rigel_bram_pkg::*;
#(
  parameter int ADDR_W   = ramb16_addr_w(1),
  parameter int AFULL_TH = 16320
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic              out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic              ram_dia,
  output logic              ram_enb,
  output logic              ram_web,
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic              ram_dob,
  output logic              ram_ssra,
  output logic              ram_ssrb
);

  localparam logic [ADDR_W:0] FULL  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AFULL = AFULL_TH[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   ram_occ;
  logic              inflight;
  logic [1:0]        skid_occ;
  logic              push, pop, fetch;
  logic [2:0]        pend;
  ram_ctl_t          ctl;

  assign in_ready    = (count < FULL);
  assign almost_full = (count >= AFULL);
  assign push        = in_valid & in_ready & ~flush;
  assign pop         = out_valid & out_ready & ~flush;

  // Skid occupancy after this edge; a fetch now lands in the skid one edge later.
  assign pend  = {1'b0, skid_occ} + {2'b00, inflight} - {2'b00, pop};
  assign fetch = ~flush & (ram_occ != '0) & (pend < 3'd2);

  always_comb begin
    ctl      = '0;
    ctl.ena  = push & reset_n;
    ctl.wea  = push & reset_n;
    ctl.enb  = fetch & reset_n;
  end

  assign ram_ena   = ctl.ena;
  assign ram_wea   = ctl.wea;
  assign ram_enb   = ctl.enb;
  assign ram_web   = ctl.web;
  assign ram_ssra  = ctl.ssra;
  assign ram_ssrb  = ctl.ssrb;
  assign ram_addra = wr_ptr;
  assign ram_dia   = in_data;
  assign ram_addrb = rd_ptr;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_occ  <= '0;
      inflight <= 1'b0;
      count    <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_occ  <= '0;
      inflight <= 1'b0;
      count    <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + ADDR_W'(1);
      if (fetch) rd_ptr <= rd_ptr + ADDR_W'(1);
      ram_occ  <= ram_occ + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, fetch};
      inflight <= fetch;
      count    <= count + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
    end
  end

  bit_skid2 u_skid (
    .clk     (CLK),
    .rst_n   (reset_n),
    .clr     (flush),
    .in_vld  (inflight),
    .in_dat  (ram_dob),
    .out_rdy (out_ready),
    .out_vld (out_valid),
    .out_dat (out_data),
    .occ     (skid_occ)
  );

endmodule

// File: tb/tb_ramb16_bit_fifo_ctrl.sv
// Random-stimulus scoreboard bench for ramb16_bit_fifo_ctrl with a behavioural 16Kx1 RAM beside it.
module tb_ramb16_bit_fifo_ctrl;

  localparam int ADDR_W   = 14;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int AFULL_TH = 16320;

  logic              CLK       = 1'b0;
  logic              reset_n   = 1'b0;
  logic              flush     = 1'b0;
  logic              in_valid  = 1'b0;
  logic              in_data   = 1'b0;
  logic              out_ready = 1'b0;
  logic              in_ready, out_valid, out_data, almost_full;
  logic [ADDR_W:0]   count;
  logic              ram_ena, ram_wea, ram_dia, ram_enb, ram_web, ram_ssra, ram_ssrb;
  logic [ADDR_W-1:0] ram_addra, ram_addrb;
  logic              ram_dob = 1'b0;

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];
  int mheld    = 0;

  logic mem [DEPTH];

  always #5 CLK = ~CLK;

  ramb16_bit_fifo_ctrl #(.ADDR_W(ADDR_W), .AFULL_TH(AFULL_TH)) dut (
    .CLK(CLK), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .almost_full(almost_full),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
    .ram_enb(ram_enb), .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_dob(ram_dob),
    .ram_ssra(ram_ssra), .ram_ssrb(ram_ssrb)
  );

  always @(posedge CLK) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= mem[ram_addrb];
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compares state against the model and pops the scoreboard on every handshake.
  always @(negedge CLK) begin : monitor
    bit pushed, popped;
    if (reset_n) begin
      chk("count", int'(count), mheld);
      chk("in_ready", int'(in_ready), int'(mheld < DEPTH));
      chk("almost_full", int'(almost_full), int'(mheld >= AFULL_TH));
      chk("count_range", int'(int'(count) <= DEPTH), 1);
      if (mheld == 0) chk("empty_no_valid", int'(out_valid), 0);
      if (ram_ena && ram_enb) chk("port_collision", int'(ram_addra != ram_addrb), 1);
      if (flush) begin
        exp_q.delete();
        mheld = 0;
      end else begin
        pushed = in_valid && (mheld < DEPTH);
        popped = out_valid && out_ready;
        if (popped) begin
          chk("pop_has_data", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) chk("out_data", int'(out_data), int'(exp_q.pop_front()));
        end
        mheld += int'(pushed) - int'(popped);
      end
    end
  end

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic cyc(input logic v, input logic d, input logic r, input logic f);
    logic ir0;
    ir0       = in_ready;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    #1;
    chk("in_ready_indep", int'(in_ready), int'(ir0));
    if (v && in_ready && !f) exp_q.push_back(d);
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((count != '0 || out_valid) && guard < 40000) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    chk({name, "_drained"}, int'(count), 0);
    chk({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic rand_stream(input int n, input int stall_pct);
    logic v, r;
    for (int i = 0; i < n; i++) begin
      v = ($urandom_range(0, 99) >= stall_pct);
      r = ($urandom_range(0, 99) >= stall_pct);
      cyc(v, 1'($urandom_range(0, 1)), r, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, guard;
    logic b, v, r;
    for (int i = 0; i < DEPTH; i++) mem[i] = 1'($urandom_range(0, 1));

    // Reset values
    #13;
    chk("rst_count", int'(count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_almost_full", int'(almost_full), 0);
    chk("rst_ram_en", int'({ram_ena, ram_wea, ram_enb, ram_web, ram_ssra, ram_ssrb}), 0);
    #10 reset_n = 1'b1;
    @(posedge CLK); #1;

    // T1: single-bit latency
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_valid_e0", int'(out_valid), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_valid_e1", int'(out_valid), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_valid_e2", int'(out_valid), 1);
    chk("t1_data", int'(out_data), 1);
    chk("t1_count", int'(count), 1);
    drain("t1");

    // T2: continuous streaming, no bubbles once filled
    for (int i = 0; i < 1000; i++) begin
      if (i >= 3) chk("t2_no_bubble", int'(out_valid), 1);
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
    drain("t2");

    // T3: fill to full, threshold and full-boundary behaviour
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (i + 1 == AFULL_TH - 1) chk("t3_af_below", int'(almost_full), 0);
      if (i + 1 == AFULL_TH)     chk("t3_af_at", int'(almost_full), 1);
    end
    chk("t3_full_count", int'(count), DEPTH);
    chk("t3_full_in_ready", int'(in_ready), 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_refused_push", int'(count), DEPTH);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t3_pop_at_full", int'(count), DEPTH - 1);
    chk("t3_slot_freed", int'(in_ready), 1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_pushpop_keeps", int'(count), DEPTH - 1);
    drain("t3");

    // T4: long random-stall stream across the pointer wrap
    sent  = 0;
    guard = 0;
    while (sent < 20000 && guard < 40000) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      if (v && in_ready) sent++;
      cyc(v, 1'($urandom_range(0, 1)), r, 1'b0);
      guard++;
    end
    chk("t4_sent", sent, 20000);
    drain("t4");

    // T5: flush with a read in flight behind a non-empty skid
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5_flush_count", int'(count), 0);
    chk("t5_flush_valid", int'(out_valid), 0);
    b = ~mem[0];
    cyc(1'b1, b, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_after_valid", int'(out_valid), 1);
    chk("t5_after_data", int'(out_data), int'(b));
    drain("t5");

    // T6: asynchronous reset pulse mid-stream
    rand_stream(40, 20);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_in_ready", int'(in_ready), 1);
    chk("t6_rst_ram_en", int'({ram_ena, ram_enb}), 0);
    exp_q.delete();
    mheld     = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #3 reset_n = 1'b1;
    @(posedge CLK); #1;
    rand_stream(300, 25);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
